// File: rtl/wb_scoreboard_if.sv
// Decode-side issue/hazard signals, execution-unit result return and register-file
// writeback port of the in-order writeback tracker.
interface wb_scoreboard_if #(
    parameter int TAGW = 2
);
    logic            issue_valid;
    logic [1:0]      issue_rw;
    logic [4:0]      issue_rd;
    logic [4:0]      issue_wait;
    logic [5:0]      src_s;
    logic [5:0]      src_t;
    logic            issue_ready;
    logic [TAGW-1:0] issue_tag;
    logic            hazard;
    logic            full;
    logic            res_valid;
    logic [TAGW-1:0] res_tag;
    logic [31:0]     res_data;
    logic [1:0]      wb_rw;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_data;
    logic            err;

    modport master (
        output issue_valid, issue_rw, issue_rd, issue_wait, src_s, src_t,
        output res_valid, res_tag, res_data,
        input  issue_ready, issue_tag, hazard, full,
        input  wb_rw, wb_rd, wb_data, err
    );

    modport slave (
        input  issue_valid, issue_rw, issue_rd, issue_wait, src_s, src_t,
        input  res_valid, res_tag, res_data,
        output issue_ready, issue_tag, hazard, full,
        output wb_rw, wb_rd, wb_data, err
    );
endinterface

// File: rtl/wb_scoreboard.sv
// In-order writeback tracker: circular queue of outstanding register writes, results
// filled by slot tag, retired oldest-first onto the register-file write port.
module wb_scoreboard #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    wb_scoreboard_if.slave bus
);
    localparam logic [TAGW:0]   FULL_CNT = (TAGW+1)'(DEPTH);
    localparam logic [TAGW-1:0] TAG_ONE  = TAGW'(1);

    logic            busy_q [DEPTH];
    logic            busy_d [DEPTH];
    logic [1:0]      cls_q  [DEPTH];
    logic [1:0]      cls_d  [DEPTH];
    logic [4:0]      rd_q   [DEPTH];
    logic [4:0]      rd_d   [DEPTH];
    logic [4:0]      cnt_q  [DEPTH];
    logic [4:0]      cnt_d  [DEPTH];
    logic            dv_q   [DEPTH];
    logic            dv_d   [DEPTH];
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [TAGW-1:0] head_q, head_d;
    logic [TAGW-1:0] tail_q, tail_d;
    logic [TAGW:0]   count_q, count_d;
    logic [1:0]      wb_rw_q, wb_rw_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic            err_q, err_d;
    logic            hazard, is_write, full, issue_ready, alloc, retire;

    // gpr $zero (tag 0) is never a real dependency, so it is excluded from matching.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && ({cls_q[i] == 2'b10, rd_q[i]} != 6'd0) &&
                (({cls_q[i] == 2'b10, rd_q[i]} == bus.src_s) ||
                 ({cls_q[i] == 2'b10, rd_q[i]} == bus.src_t))) begin
                hazard = 1'b1;
            end
        end
    end

    assign is_write    = (bus.issue_rw == 2'b01) || (bus.issue_rw == 2'b10);
    assign full        = (count_q == FULL_CNT);
    assign issue_ready = !hazard && (!is_write || !full);
    assign alloc       = bus.issue_valid && issue_ready && is_write;

    always_comb begin
        busy_d    = busy_q;
        cls_d     = cls_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        dv_d      = dv_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        wb_rw_d   = 2'b00;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        retire    = busy_q[head_q] && dv_q[head_q] && (cnt_q[head_q] == 5'd0);

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && (cnt_q[i] != 5'd0)) begin
                cnt_d[i] = cnt_q[i] - 5'd1;
            end
        end

        if (bus.res_valid) begin
            if (busy_q[bus.res_tag] && !dv_q[bus.res_tag]) begin
                data_d[bus.res_tag] = bus.res_data;
                dv_d[bus.res_tag]   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (retire) begin
            wb_rw_d        = cls_q[head_q];
            wb_rd_d        = rd_q[head_q];
            wb_data_d      = data_q[head_q];
            busy_d[head_q] = 1'b0;
            dv_d[head_q]   = 1'b0;
            head_d         = head_q + TAG_ONE;
        end

        // Allocation overrides the decrement loop for the tail slot; it was idle anyway.
        if (alloc) begin
            busy_d[tail_q] = 1'b1;
            cls_d[tail_q]  = bus.issue_rw;
            rd_d[tail_q]   = bus.issue_rd;
            cnt_d[tail_q]  = (bus.issue_wait == 5'd0) ? 5'd1 : bus.issue_wait;
            dv_d[tail_q]   = 1'b0;
            tail_d         = tail_q + TAG_ONE;
        end

        count_d = count_q + (TAGW+1)'(alloc) - (TAGW+1)'(retire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                busy_q[i] <= 1'b0;
                cls_q[i]  <= '0;
                rd_q[i]   <= '0;
                cnt_q[i]  <= '0;
                dv_q[i]   <= 1'b0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wb_rw_q   <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cls_q     <= cls_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            dv_q      <= dv_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wb_rw_q   <= wb_rw_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign bus.issue_ready = issue_ready;
    assign bus.issue_tag   = tail_q;
    assign bus.hazard      = hazard;
    assign bus.full        = full;
    assign bus.wb_rw       = wb_rw_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: a queue of pending writes predicts hazards,
// acceptance, tags, error flag and the exact edge, order and content of each writeback.
module tb_wb_scoreboard;
    localparam int DEPTH = 4;
    localparam int TAGW  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_scoreboard_if #(.TAGW(TAGW)) bus ();
    wb_scoreboard #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [1:0]  tag;
        int          e;     // edge at which the instruction was accepted
        int          w;     // effective wait, at least 1
        bit          dv;
        int          r;     // edge at which the result was accepted
        logic [31:0] data;
    } entry_t;

    entry_t exp_q[$];
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int last_ret = -100;
    int tail_m = 0;
    bit err_exp = 1'b0;
    bit prev_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Retire edge: the slot must have counted down, have data, and the previous write must be out.
    function automatic int ret_edge(entry_t h);
        int m;
        m = h.e + h.w;
        if (h.r > m) m = h.r;
        if (last_ret > m) m = last_ret;
        return m + 1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.wb_rw != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 32'(bus.wb_rw), 32'd0);
                end else begin
                    entry_t h;
                    int     x;
                    h = exp_q.pop_front();
                    x = h.dv ? ret_edge(h) : -1;
                    chk("wb_rw", 32'(bus.wb_rw), 32'(h.cls));
                    chk("wb_rd", 32'(bus.wb_rd), 32'(h.rd));
                    chk("wb_data", bus.wb_data, h.data);
                    chk("wb_cycle", cyc, x);
                    last_ret = cyc;
                end
            end else if (exp_q.size() > 0 && exp_q[0].dv && ret_edge(exp_q[0]) == cyc) begin
                chk("wb_missing", 32'(bus.wb_rw), 32'(exp_q[0].cls));
                void'(exp_q.pop_front());
                last_ret = cyc;
            end
        end
    end

    task automatic step(input bit iv, input logic [1:0] rw, input logic [4:0] rd,
                        input logic [4:0] wt, input logic [5:0] ss, input logic [5:0] st,
                        input bit rv, input logic [1:0] rt, input logic [31:0] rdata,
                        input bit do_rst);
        bit haz;
        bit wr;
        bit rdy;
        int hit;
        entry_t n;
        @(negedge clk);
        rst = do_rst;
        bus.issue_valid = iv && !do_rst;
        bus.issue_rw    = rw;
        bus.issue_rd    = rd;
        bus.issue_wait  = wt;
        bus.src_s       = ss;
        bus.src_t       = st;
        bus.res_valid   = rv && !do_rst;
        bus.res_tag     = rt;
        bus.res_data    = rdata;
        haz = 1'b0;
        foreach (exp_q[i]) begin
            logic [5:0] tg;
            tg = {exp_q[i].cls == 2'b10, exp_q[i].rd};
            if (tg != 6'd0 && (tg == ss || tg == st)) haz = 1'b1;
        end
        wr  = (rw == 2'b01) || (rw == 2'b10);
        rdy = !haz && (!wr || exp_q.size() < DEPTH);
        #1;
        if (prev_rst) begin
            chk("rst_wb_rw", 32'(bus.wb_rw), 32'd0);
            chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
            chk("rst_wb_data", bus.wb_data, 32'd0);
        end
        if (!do_rst) begin
            chk("hazard", 32'(bus.hazard), 32'(haz));
            chk("issue_ready", 32'(bus.issue_ready), 32'(rdy));
            chk("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
            chk("err", 32'(bus.err), 32'(err_exp));
            if (iv && wr && rdy) chk("issue_tag", 32'(bus.issue_tag), tail_m);
        end
        prev_rst = do_rst;
        if (do_rst) begin
            exp_q.delete();
            err_exp  = 1'b0;
            tail_m   = 0;
            last_ret = -100;
        end else begin
            if (rv) begin
                hit = -1;
                foreach (exp_q[i]) if (exp_q[i].tag == rt) hit = i;
                if (hit >= 0 && !exp_q[hit].dv) begin
                    exp_q[hit].dv   = 1'b1;
                    exp_q[hit].data = rdata;
                    exp_q[hit].r    = cyc + 1;
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (iv && wr && rdy) begin
                n.cls  = rw;
                n.rd   = rd;
                n.tag  = 2'(tail_m);
                n.e    = cyc + 1;
                n.w    = (wt == 5'd0) ? 1 : int'(wt);
                n.dv   = 1'b0;
                n.r    = 0;
                n.data = '0;
                exp_q.push_back(n);
                tail_m = (tail_m + 1) % DEPTH;
            end
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) begin
            int p;
            p = -1;
            foreach (exp_q[i]) if (!exp_q[i].dv) p = i;
            if (p >= 0) step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, exp_q[p].tag, $urandom, 0);
            else idle(1);
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 32'd0);
        idle(2);
    endtask

    function automatic logic [5:0] pick_src();
        if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            int i;
            i = $urandom_range(0, exp_q.size() - 1);
            return {exp_q[i].cls == 2'b10, exp_q[i].rd};
        end
        return {1'($urandom), 5'($urandom_range(0, 7))};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bus.issue_valid = 1'b0;
        bus.res_valid   = 1'b0;
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 0, 2'd0, 32'd0, 1);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 0, 2'd0, 32'd0, 1);
        idle(2);

        // single gpr write: expected at issue edge + 4
        step(1, 2'b01, 5'd5, 5'd3, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, 2'd0, 32'hDEADBEEF, 0);
        idle(6);

        // RAW hazard on fpr 2; gpr $zero source never blocks
        t = tail_m;
        step(1, 2'b10, 5'd2, 5'd6, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
        for (int k = 0; k < 10; k++)
            step(1, 2'b01, 5'd9, 5'd1, 6'b000000, 6'b100010, k == 1, 2'(t), 32'h0F0F_1234, 0);
        drain();

        // fill all slots, then a non-writing instruction still gets in
        for (int k = 1; k <= 4; k++) step(1, 2'b01, 5'(k), 5'd2, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
        step(1, 2'b01, 5'd7, 5'd1, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
        step(1, 2'b00, 5'd7, 5'd1, 6'b111111, 6'b011110, 0, 2'd0, 32'd0, 0);
        step(1, 2'b11, 5'd8, 5'd1, 6'b111110, 6'b011101, 0, 2'd0, 32'd0, 0);
        drain();

        // results out of order, writebacks in issue order
        for (int k = 1; k <= 3; k++) step(1, 2'b01, 5'(k), 5'd1, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, exp_q[2].tag, 32'hC0DE_0003, 0);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, exp_q[0].tag, 32'hC0DE_0001, 0);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, exp_q[1].tag, 32'hC0DE_0002, 0);
        idle(6);

        // result to an empty slot is a sticky error
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, 2'd3, 32'h1111_2222, 0);
        idle(4);

        // reset with writes pending; a late result is then an error
        for (int k = 10; k < 13; k++) step(1, 2'b01, 5'(k), 5'd4, 6'd0, 6'd0, 0, 2'd0, 32'd0, 0);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 0, 2'd0, 32'd0, 1);
        step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 1, 2'd0, 32'h5555_AAAA, 0);
        idle(5);

        for (int n = 0; n < 1500; n++) begin
            logic [5:0] ss;
            logic [5:0] st;
            logic [1:0] rt;
            bit rv;
            if ($urandom_range(0, 199) == 0) begin
                step(0, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 0, 2'd0, 32'd0, 1);
            end else begin
                ss = pick_src();
                st = pick_src();
                rv = ($urandom_range(0, 99) < 55);
                rt = 2'($urandom_range(0, 3));
                if (rv && exp_q.size() > 0 && $urandom_range(0, 9) < 8)
                    rt = exp_q[$urandom_range(0, exp_q.size() - 1)].tag;
                step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 6)), ss, st, rv, rt, $urandom, 0);
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
